memory_router: RTL and testbench

MEMORY_ROUTER -- requirements
Module: memory_router

---
 rtl/memory_map_pkg.sv | 25 ++
 rtl/memory_region_decoder.sv | 49 ++++
 rtl/memory_router.sv | 145 ++++++++++++++
 tb/tb_memory_router.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_map_pkg.sv
// Shared address-map constants, region classification and router FSM states.
package memory_map_pkg;

  localparam logic [31:0] TEXT_BASE = 32'h0000_0000;
  localparam logic [31:0] TEXT_END  = 32'h0FFF_FFFF;
  localparam logic [31:0] DATA_BASE = 32'h1000_0000;
  localparam logic [31:0] DATA_END  = 32'h7FFF_FFFF;
  localparam logic [31:0] IO_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] IO_END    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    TEXT,
    DATA,
    IO,
    UNMAPPED
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/memory_region_decoder.sv
// Combinational virtual-address decoder: region, bounds check and target-local word address.
module memory_region_decoder
  import memory_map_pkg::*;
#(
  parameter int unsigned PHYS_ADDR_BITS  = 11,
  parameter int unsigned IO_ADDR_BITS    = 4,
  parameter int unsigned DS_OFFSET_SHIFT = 1
) (
  input  logic [31:0]               address,
  output region_t                   region,
  output logic                      in_bounds,
  output logic [PHYS_ADDR_BITS-1:0] phys_offset,
  output logic [IO_ADDR_BITS-1:0]   io_offset
);

  localparam logic [31:0] PHYS_SIZE = 32'(1) << PHYS_ADDR_BITS;
  localparam logic [31:0] HALF      = PHYS_SIZE >> DS_OFFSET_SHIFT;
  localparam logic [31:0] IO_SIZE   = 32'(1) << IO_ADDR_BITS;

  logic [31:0] offset;

  always_comb begin
    region = UNMAPPED;
    offset = '0;
    if (address <= TEXT_END) begin
      region = TEXT;
      offset = address - TEXT_BASE;
    end else if (address >= DATA_BASE && address <= DATA_END) begin
      region = DATA;
      offset = address - DATA_BASE;
    end else if (address >= IO_BASE) begin
      region = IO;
      offset = address - IO_BASE;
    end

    case (region)
      TEXT:    in_bounds = offset < HALF;
      DATA:    in_bounds = offset < (PHYS_SIZE - HALF);
      IO:      in_bounds = offset < IO_SIZE;
      default: in_bounds = 1'b0;
    endcase

    // Data segment sits in the upper part of physical memory.
    phys_offset = (region == DATA) ? PHYS_ADDR_BITS'(offset + HALF)
                                   : PHYS_ADDR_BITS'(offset);
    io_offset   = IO_ADDR_BITS'(offset);
  end

endmodule

// File: rtl/memory_router.sv
// Routes CPU virtual accesses to physical memory or IO with fixed wait states.
// Optional macro TEXT_WP_EN: writes to the TEXT region fault instead of being forwarded.
module memory_router
  import memory_map_pkg::*;
#(
  parameter int unsigned PHYS_ADDR_BITS  = 11,
  parameter int unsigned IO_ADDR_BITS    = 4,
  parameter int unsigned DS_OFFSET_SHIFT = 1,
  parameter int unsigned PHYS_WAIT       = 1,
  parameter int unsigned IO_WAIT         = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reqVirt,
  input  logic                      wEnVirt,
  input  logic [31:0]               addressVirt,
  input  logic [31:0]               dataInVirt,
  output logic                      readyVirt,
  output logic [31:0]               dataOutVirt,
  output logic                      faultVirt,
  output logic [PHYS_ADDR_BITS-1:0] addressPhys,
  output logic [31:0]               dataInPhys,
  input  logic [31:0]               dataOutPhys,
  output logic                      wEnPhys,
  output logic                      rstPhys,
  output logic [IO_ADDR_BITS-1:0]   addressIO,
  output logic [31:0]               dataInIO,
  input  logic [31:0]               dataOutIO,
  output logic                      wEnIO,
  output logic                      rstIO
);

`ifdef TEXT_WP_EN
  localparam logic TEXT_WP = 1'b1;
`else
  localparam logic TEXT_WP = 1'b0;
`endif

  localparam logic [3:0] PHYS_WAIT_C = 4'(PHYS_WAIT);
  localparam logic [3:0] IO_WAIT_C   = 4'(IO_WAIT);

  state_t                    state, state_next;
  region_t                   dec_region;
  logic                      dec_in_bounds;
  logic [PHYS_ADDR_BITS-1:0] dec_phys;
  logic [IO_ADDR_BITS-1:0]   dec_io;
  logic                      req_fault;
  region_t                   req_region;
  logic                      req_we;
  logic [3:0]                wait_cnt;
  logic [3:0]                wait_load;
  logic                      resp_entry;

  assign rstPhys = rst;
  assign rstIO   = rst;

  memory_region_decoder #(
    .PHYS_ADDR_BITS (PHYS_ADDR_BITS),
    .IO_ADDR_BITS   (IO_ADDR_BITS),
    .DS_OFFSET_SHIFT(DS_OFFSET_SHIFT)
  ) u_decoder (
    .address    (addressVirt),
    .region     (dec_region),
    .in_bounds  (dec_in_bounds),
    .phys_offset(dec_phys),
    .io_offset  (dec_io)
  );

  always_comb begin
    req_fault = !dec_in_bounds || (dec_region == UNMAPPED) ||
                (TEXT_WP && dec_region == TEXT && wEnVirt);
    wait_load = (req_region == IO) ? IO_WAIT_C : PHYS_WAIT_C;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (reqVirt) state_next = req_fault ? RESP : ACCESS;
      ACCESS:  state_next = (wait_load != 4'd0) ? WAIT : RESP;
      WAIT:    if (wait_cnt <= 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    resp_entry = (state_next == RESP) && (state != RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      readyVirt   <= 1'b0;
      faultVirt   <= 1'b0;
      dataOutVirt <= '0;
      addressPhys <= '0;
      dataInPhys  <= '0;
      wEnPhys     <= 1'b0;
      addressIO   <= '0;
      dataInIO    <= '0;
      wEnIO       <= 1'b0;
      wait_cnt    <= '0;
      req_region  <= UNMAPPED;
      req_we      <= 1'b0;
    end else begin
      readyVirt <= resp_entry;
      faultVirt <= resp_entry && (state == IDLE);
      wEnPhys   <= 1'b0;
      wEnIO     <= 1'b0;

      case (state)
        IDLE: if (reqVirt) begin
          req_region <= dec_region;
          req_we     <= wEnVirt;
          // Target outputs are loaded here so they are already visible in the ACCESS cycle.
          if (!req_fault) begin
            if (dec_region == IO) begin
              addressIO <= dec_io;
              dataInIO  <= dataInVirt;
              wEnIO     <= wEnVirt;
            end else begin
              addressPhys <= dec_phys;
              dataInPhys  <= dataInVirt;
              wEnPhys     <= wEnVirt;
            end
          end
        end
        ACCESS:  wait_cnt <= wait_load;
        WAIT:    wait_cnt <= wait_cnt - 4'd1;
        default: ;
      endcase

      if (resp_entry) begin
        dataOutVirt <= (state == IDLE || req_we) ? '0
                     : ((req_region == IO) ? dataOutIO : dataOutPhys);
        addressPhys <= '0;
        dataInPhys  <= '0;
        addressIO   <= '0;
        dataInIO    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_router.sv
// Self-checking bench for memory_router: directed boundary cases plus randomized traffic vs. an address-map model.
module tb_memory_router;

  localparam int PHYS_BITS = 11;
  localparam int IO_BITS   = 4;
  localparam int P_WAIT    = 1;
  localparam int I_WAIT    = 0;
  localparam longint PSIZE = 64'd1 << PHYS_BITS;
  localparam longint HALF  = PSIZE >> 1;
  localparam longint IOSZ  = 64'd1 << IO_BITS;

`ifdef TEXT_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 reqVirt, wEnVirt;
  logic [31:0]          addressVirt, dataInVirt;
  logic                 readyVirt, faultVirt;
  logic [31:0]          dataOutVirt;
  logic [PHYS_BITS-1:0] addressPhys;
  logic [31:0]          dataInPhys, dataOutPhys;
  logic                 wEnPhys, rstPhys;
  logic [IO_BITS-1:0]   addressIO;
  logic [31:0]          dataInIO, dataOutIO;
  logic                 wEnIO, rstIO;

  int total = 0;
  int bad   = 0;

  memory_router #(
    .PHYS_ADDR_BITS (PHYS_BITS),
    .IO_ADDR_BITS   (IO_BITS),
    .DS_OFFSET_SHIFT(1),
    .PHYS_WAIT      (P_WAIT),
    .IO_WAIT        (I_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .reqVirt(reqVirt), .wEnVirt(wEnVirt),
    .addressVirt(addressVirt), .dataInVirt(dataInVirt),
    .readyVirt(readyVirt), .dataOutVirt(dataOutVirt), .faultVirt(faultVirt),
    .addressPhys(addressPhys), .dataInPhys(dataInPhys), .dataOutPhys(dataOutPhys),
    .wEnPhys(wEnPhys), .rstPhys(rstPhys),
    .addressIO(addressIO), .dataInIO(dataInIO), .dataOutIO(dataOutIO),
    .wEnIO(wEnIO), .rstIO(rstIO)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   ready_cyc;
    logic                 fault;
    logic [31:0]          dout;
    int                   n_wp;
    int                   n_wio;
    bit                   overlap;
    logic [PHYS_BITS-1:0] ap;
    logic [31:0]          dp;
    logic [IO_BITS-1:0]   aio;
    logic [31:0]          dio;
    logic                 ready_after;
  } obs_t;

  typedef struct {
    bit                   fault;
    bit                   io;
    logic [PHYS_BITS-1:0] ap;
    logic [IO_BITS-1:0]   aio;
    int                   lat;
  } exp_t;

  function automatic exp_t model(input logic [31:0] a, input logic we);
    exp_t   e;
    longint off;
    bit     ok;
    e.io = 1'b0; e.ap = '0; e.aio = '0;
    if (a < 32'h1000_0000) begin
      off  = longint'(a);
      ok   = (off < HALF) && !(WP && we);
      e.ap = PHYS_BITS'(off);
    end else if (a < 32'h8000_0000) begin
      off  = longint'(a) - 64'h1000_0000;
      ok   = off < (PSIZE - HALF);
      e.ap = PHYS_BITS'(off + HALF);
    end else if (a >= 32'hFFFF_0000) begin
      off   = longint'(a) - 64'hFFFF_0000;
      ok    = off < IOSZ;
      e.io  = 1'b1;
      e.aio = IO_BITS'(off);
    end else begin
      ok = 1'b0;
    end
    e.fault = !ok;
    if (!ok) begin e.ap = '0; e.aio = '0; e.io = 1'b0; end
    e.lat = e.fault ? 1 : (e.io ? I_WAIT + 2 : P_WAIT + 2);
    return e;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0:       return 32'($urandom_range(0, 1023));
      1:       return 32'($urandom_range(1024, 32'h0FFF_FFFF));
      2:       return 32'h1000_0000 + 32'($urandom_range(0, 1023));
      3:       return 32'h1000_0400 + 32'($urandom_range(0, 255));
      4:       return 32'hFFFF_0000 + 32'($urandom_range(0, 15));
      5:       return 32'hFFFF_0000 + 32'($urandom_range(16, 65535));
      default: return 32'($urandom_range(32'h8000_0000, 32'hFFFE_FFFF));
    endcase
  endfunction

  // Issues one request from an IDLE negedge and observes it; returns at the negedge after ready.
  task automatic run_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [31:0] pr, input logic [31:0] ior, input bit hold,
                         output obs_t o);
    o.ready_cyc = -1; o.fault = 1'bx; o.dout = 'x;
    o.n_wp = 0; o.n_wio = 0; o.overlap = 1'b0;
    o.ap = 'x; o.dp = 'x; o.aio = 'x; o.dio = 'x;
    addressVirt = a; wEnVirt = we; dataInVirt = wd;
    dataOutPhys = pr; dataOutIO = ior; reqVirt = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!hold) reqVirt = 1'b0;
      if (k == 1) begin
        o.ap = addressPhys; o.dp = dataInPhys; o.aio = addressIO; o.dio = dataInIO;
      end
      if (wEnPhys) o.n_wp++;
      if (wEnIO) o.n_wio++;
      if (wEnPhys && wEnIO) o.overlap = 1'b1;
      if (readyVirt) begin
        o.ready_cyc = k; o.fault = faultVirt; o.dout = dataOutVirt;
        break;
      end
    end
    @(negedge clk);
    o.ready_after = readyVirt;
  endtask

  task automatic test_reset();
    rst = 1'b1; reqVirt = 1'b1; wEnVirt = 1'b1;
    addressVirt = 32'h1000_0010; dataInVirt = $urandom;
    dataOutPhys = $urandom; dataOutIO = $urandom;
    repeat (2) @(negedge clk);
    total++;
    if ({readyVirt, faultVirt, dataOutVirt, addressPhys, dataInPhys, wEnPhys,
         addressIO, dataInIO, wEnIO} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b fault=%b dout=%h ap=%h dp=%h wp=%b aio=%h dio=%h wio=%b, required all 0",
               readyVirt, faultVirt, dataOutVirt, addressPhys, dataInPhys, wEnPhys, addressIO, dataInIO, wEnIO);
    end
    total++;
    if ({rstPhys, rstIO} !== 2'b11) begin
      bad++; $display("FAIL reset_follow_high: rstPhys/rstIO=%b, required 11", {rstPhys, rstIO});
    end
    reqVirt = 1'b0; rst = 1'b0;
    #1;
    total++;
    if ({rstPhys, rstIO} !== 2'b00) begin
      bad++; $display("FAIL reset_follow_low: rstPhys/rstIO=%b, required 00", {rstPhys, rstIO});
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] a; logic we; logic [31:0] wd; logic [31:0] pr; logic [31:0] ior;
    int lat; logic fault; logic [31:0] dout;
    logic [PHYS_BITS-1:0] ap; logic [31:0] dp; logic [IO_BITS-1:0] aio; int nwe;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[$];
    obs_t o;
    tbl.push_back('{32'h0000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 11'h010, 32'h0, 4'h0, 0});
    tbl.push_back('{32'h1000_0004, 1'b1, 32'h1234, 32'h55, 32'h0, 3, 1'b0, 32'h0, 11'h404, 32'h1234, 4'h0, 1});
    tbl.push_back('{32'hFFFF_0003, 1'b0, 32'h0, 32'h0, 32'hA5, 2, 1'b0, 32'hA5, 11'h000, 32'h0, 4'h3, 0});
    tbl.push_back('{32'h8000_0000, 1'b0, 32'h0, 32'h77, 32'h66, 1, 1'b1, 32'h0, 11'h000, 32'h0, 4'h0, 0});
    tbl.push_back('{32'h0000_0400, 1'b0, 32'h0, 32'h77, 32'h66, 1, 1'b1, 32'h0, 11'h000, 32'h0, 4'h0, 0});
    tbl.push_back('{32'h0000_03FF, 1'b0, 32'h0, 32'h1111, 32'h0, 3, 1'b0, 32'h1111, 11'h3FF, 32'h0, 4'h0, 0});
    tbl.push_back('{32'h1000_03FF, 1'b1, 32'hABCD, 32'h0, 32'h0, 3, 1'b0, 32'h0, 11'h7FF, 32'hABCD, 4'h0, 1});
    tbl.push_back('{32'h1000_0400, 1'b1, 32'hABCD, 32'h0, 32'h0, 1, 1'b1, 32'h0, 11'h000, 32'h0, 4'h0, 0});
    tbl.push_back('{32'hFFFF_000F, 1'b1, 32'h5A, 32'h0, 32'h0, 2, 1'b0, 32'h0, 11'h000, 32'h0, 4'hF, 1});
    tbl.push_back('{32'hFFFF_0010, 1'b1, 32'h5A, 32'h0, 32'h0, 1, 1'b1, 32'h0, 11'h000, 32'h0, 4'h0, 0});
    tbl.push_back('{32'hFFFE_FFFF, 1'b1, 32'h5A, 32'h0, 32'h0, 1, 1'b1, 32'h0, 11'h000, 32'h0, 4'h0, 0});
    if (WP) tbl.push_back('{32'h0, 1'b1, 32'hCAFE, 32'h0, 32'h0, 1, 1'b1, 32'h0, 11'h000, 32'h0, 4'h0, 0});
    else    tbl.push_back('{32'h0, 1'b1, 32'hCAFE, 32'h0, 32'h0, 3, 1'b0, 32'h0, 11'h000, 32'hCAFE, 4'h0, 1});
    foreach (tbl[i]) begin
      run_txn(tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].pr, tbl[i].ior, 1'b0, o);
      total++;
      if (o.ready_cyc !== tbl[i].lat) begin
        bad++; $display("FAIL dir_latency[%h]: got %0d, required %0d", tbl[i].a, o.ready_cyc, tbl[i].lat);
      end
      total++;
      if ({o.fault, o.dout} !== {tbl[i].fault, tbl[i].dout}) begin
        bad++; $display("FAIL dir_resp[%h]: fault=%b dout=%h, required fault=%b dout=%h",
                        tbl[i].a, o.fault, o.dout, tbl[i].fault, tbl[i].dout);
      end
      total++;
      if ({o.ap, o.dp, o.aio} !== {tbl[i].ap, tbl[i].dp, tbl[i].aio}) begin
        bad++; $display("FAIL dir_target[%h]: ap=%h dp=%h aio=%h, required ap=%h dp=%h aio=%h",
                        tbl[i].a, o.ap, o.dp, o.aio, tbl[i].ap, tbl[i].dp, tbl[i].aio);
      end
      total++;
      if ((o.n_wp + o.n_wio) !== tbl[i].nwe || o.ready_after !== 1'b0) begin
        bad++; $display("FAIL dir_wen_pulse[%h]: wen_cycles=%0d ready_after=%b, required %0d and 0",
                        tbl[i].a, o.n_wp + o.n_wio, o.ready_after, tbl[i].nwe);
      end
    end
  endtask

  task automatic check_random(input string tag, input logic [31:0] a, input logic we,
                              input logic [31:0] wd, input logic [31:0] pr,
                              input logic [31:0] ior, input bit hold);
    exp_t e;
    obs_t o;
    logic [31:0] exp_dout;
    e = model(a, we);
    exp_dout = (e.fault || we) ? 32'h0 : (e.io ? ior : pr);
    run_txn(a, we, wd, pr, ior, hold, o);
    total++;
    if (o.ready_cyc !== e.lat || o.fault !== e.fault || o.dout !== exp_dout) begin
      bad++; $display("FAIL %s_resp[%h we=%b]: lat=%0d fault=%b dout=%h, required lat=%0d fault=%b dout=%h",
                      tag, a, we, o.ready_cyc, o.fault, o.dout, e.lat, e.fault, exp_dout);
    end
    total++;
    if (o.ap !== e.ap || o.aio !== e.aio ||
        o.dp !== ((!e.fault && !e.io) ? wd : 32'h0) || o.dio !== ((!e.fault && e.io) ? wd : 32'h0)) begin
      bad++; $display("FAIL %s_target[%h]: ap=%h aio=%h dp=%h dio=%h, required ap=%h aio=%h",
                      tag, a, o.ap, o.aio, o.dp, o.dio, e.ap, e.aio);
    end
    total++;
    if (o.n_wp !== int'(!e.fault && !e.io && we) || o.n_wio !== int'(!e.fault && e.io && we) ||
        o.overlap || o.ready_after !== 1'b0) begin
      bad++; $display("FAIL %s_wen[%h we=%b]: wp=%0d wio=%0d overlap=%b ready_after=%b",
                      tag, a, we, o.n_wp, o.n_wio, o.overlap, o.ready_after);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++)
      check_random("rand", rand_addr(), 1'($urandom), $urandom, $urandom, $urandom, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++)
      check_random("b2b", rand_addr(), 1'($urandom), $urandom, $urandom, $urandom, 1'b1);
    reqVirt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int   stray;
    obs_t o;
    addressVirt = 32'h1000_0020; wEnVirt = 1'b0; dataInVirt = 32'h0;
    dataOutPhys = 32'h1357_9BDF; reqVirt = 1'b1;
    @(negedge clk);
    reqVirt = 1'b0;
    @(negedge clk);
    total++;
    if (addressPhys !== 11'h420) begin
      bad++; $display("FAIL abort_wait_addr: got %h, required 420", addressPhys);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({readyVirt, faultVirt, dataOutVirt, addressPhys, dataInPhys, wEnPhys,
         addressIO, dataInIO, wEnIO} !== '0) begin
      bad++; $display("FAIL abort_outputs: ready=%b dout=%h ap=%h, required all 0",
                      readyVirt, dataOutVirt, addressPhys);
    end
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (readyVirt) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++; $display("FAIL abort_no_ready: got %0d ready pulses, required 0", stray);
    end
    run_txn(32'h1000_0020, 1'b0, 32'h0, 32'h2468_ACE0, 32'h0, 1'b0, o);
    total++;
    if (o.ready_cyc !== 3 || o.dout !== 32'h2468_ACE0 || o.fault !== 1'b0) begin
      bad++; $display("FAIL abort_recover: lat=%0d dout=%h fault=%b, required 3 2468ace0 0",
                      o.ready_cyc, o.dout, o.fault);
    end
  endtask

  initial begin
    rst = 1'b1; reqVirt = 1'b0; wEnVirt = 1'b0;
    addressVirt = '0; dataInVirt = '0; dataOutPhys = '0; dataOutIO = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
